menu_sel_ctl: RTL and testbench

- Parametrised successor to the PONG menu stage. Overlays N vertically stacked menu buttons on the incoming VGA stream.
- Hit-tests the mouse cursor against the buttons and highlights the hovered or pressed button.
- Runs a press/release selection FSM and emits a one-cycle selection pulse carrying the chosen item index.
- Sits between the background stage and the final VGA output register; timing signals pass through with fixed latency.

---
 rtl/menu_sel_ctl_pkg.sv | 21 ++
 rtl/menu_hit_test.sv | 44 ++++
 rtl/menu_sel_ctl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_menu_sel_ctl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_sel_ctl_pkg.sv
// rtl/menu_sel_ctl_pkg.sv - shared types and constants for the menu selection stage
package menu_sel_ctl_pkg;

    localparam int VGA_CNT_W = 11;
    localparam int RGB_W     = 12;
    localparam int POS_W     = 12;

    localparam logic [11:0] COL_BTN_DEF = 12'h448;
    localparam logic [11:0] COL_HOV_DEF = 12'h88F;
    localparam logic [11:0] COL_PRS_DEF = 12'hFF0;
    localparam logic [11:0] COL_CURSOR  = 12'hFFF;
    localparam logic [11:0] COL_BLANK   = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_SELECT  = 2'd2,
        ST_DONE    = 2'd3
    } sel_state_t;

endpackage

// File: rtl/menu_hit_test.sv
// rtl/menu_hit_test.sv - combinational map of a 12-bit (x, y) point to the menu item it lies in
//   x, y : point to test (12 bits; anything with bit 11 set never hits)
//   hit  : point lies inside one of the N_ITEMS buttons
//   idx  : index of that button (0 when no hit)
module menu_hit_test
    import menu_sel_ctl_pkg::*;
#(
    parameter int N_ITEMS = 3,
    parameter int IDX_W   = 3,
    parameter int BTN_X   = 272,
    parameter int BTN_W   = 256,
    parameter int BTN_Y0  = 160,
    parameter int BTN_H   = 64,
    parameter int BTN_GAP = 32
) (
    input  logic [POS_W-1:0] x,
    input  logic [POS_W-1:0] y,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    int xi;
    int yi;
    int top;

    // Bounds are half-open; buttons never overlap so at most one k matches.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        xi  = int'(x);
        yi  = int'(y);
        top = 0;
        if (!x[POS_W-1] && !y[POS_W-1] && (xi >= BTN_X) && (xi < BTN_X + BTN_W)) begin
            for (int k = 0; k < N_ITEMS; k++) begin
                top = BTN_Y0 + k * (BTN_H + BTN_GAP);
                if ((yi >= top) && (yi < top + BTN_H)) begin
                    hit = 1'b1;
                    idx = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/menu_sel_ctl.sv
// rtl/menu_sel_ctl.sv - menu button overlay, mouse hit-test and press/release selection FSM
//   pclk, rst (async, active-low)
//   hcount_in/vcount_in/hsync_in/vsync_in/hblnk_in/vblnk_in/rgb_in : incoming VGA stream
//   xpos, ypos, mouse_left, menu_en                                : mouse and menu control
//   *_out                                                          : VGA stream delayed 2 cycles
//   hover_idx, hover_vld, sel_idx, sel_pulse                       : selection status
//   MENU_CURSOR_EN : when defined, draws a white crosshair at the latched mouse position
module menu_sel_ctl
    import menu_sel_ctl_pkg::*;
#(
    parameter int          N_ITEMS = 3,
    parameter int          IDX_W   = 3,
    parameter int          BTN_X   = 272,
    parameter int          BTN_W   = 256,
    parameter int          BTN_Y0  = 160,
    parameter int          BTN_H   = 64,
    parameter int          BTN_GAP = 32,
    parameter logic [11:0] COL_BTN = COL_BTN_DEF,
    parameter logic [11:0] COL_HOV = COL_HOV_DEF,
    parameter logic [11:0] COL_PRS = COL_PRS_DEF
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [VGA_CNT_W-1:0] hcount_in,
    input  logic [VGA_CNT_W-1:0] vcount_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 hblnk_in,
    input  logic                 vblnk_in,
    input  logic [RGB_W-1:0]     rgb_in,
    input  logic [POS_W-1:0]     xpos,
    input  logic [POS_W-1:0]     ypos,
    input  logic                 mouse_left,
    input  logic                 menu_en,
    output logic [VGA_CNT_W-1:0] hcount_out,
    output logic [VGA_CNT_W-1:0] vcount_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 hblnk_out,
    output logic                 vblnk_out,
    output logic [RGB_W-1:0]     rgb_out,
    output logic [IDX_W-1:0]     hover_idx,
    output logic                 hover_vld,
    output logic [IDX_W-1:0]     sel_idx,
    output logic                 sel_pulse
);

    // Stage 1 pipeline registers
    logic [VGA_CNT_W-1:0] p1_hcount;
    logic [VGA_CNT_W-1:0] p1_vcount;
    logic                 p1_hsync;
    logic                 p1_vsync;
    logic                 p1_hblnk;
    logic                 p1_vblnk;
    logic [RGB_W-1:0]     p1_rgb;
    logic                 p1_hit;
    logic [IDX_W-1:0]     p1_idx;
    logic                 p1_en;

    logic                 pix_hit;
    logic [IDX_W-1:0]     pix_idx;
    logic [RGB_W-1:0]     pix_rgb;

    // Mouse position latch and hover
    logic                 vsync_prev;
    logic [POS_W-1:0]     lat_x;
    logic [POS_W-1:0]     lat_y;
    logic                 mouse_hit;
    logic [IDX_W-1:0]     mouse_idx;

    // Button synchroniser and edge detect
    logic [1:0]           ml_sync;
    logic                 ml_prev;
    logic                 press_edge;
    logic                 release_edge;

    // Selection FSM
    sel_state_t           state;
    sel_state_t           state_nxt;
    logic [IDX_W-1:0]     press_idx;
    logic [IDX_W-1:0]     press_idx_nxt;
    logic [IDX_W-1:0]     sel_idx_nxt;

    menu_hit_test #(
        .N_ITEMS (N_ITEMS),
        .IDX_W   (IDX_W),
        .BTN_X   (BTN_X),
        .BTN_W   (BTN_W),
        .BTN_Y0  (BTN_Y0),
        .BTN_H   (BTN_H),
        .BTN_GAP (BTN_GAP)
    ) u_pix_hit (
        .x   ({1'b0, hcount_in}),
        .y   ({1'b0, vcount_in}),
        .hit (pix_hit),
        .idx (pix_idx)
    );

    menu_hit_test #(
        .N_ITEMS (N_ITEMS),
        .IDX_W   (IDX_W),
        .BTN_X   (BTN_X),
        .BTN_W   (BTN_W),
        .BTN_Y0  (BTN_Y0),
        .BTN_H   (BTN_H),
        .BTN_GAP (BTN_GAP)
    ) u_mouse_hit (
        .x   (lat_x),
        .y   (lat_y),
        .hit (mouse_hit),
        .idx (mouse_idx)
    );

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            p1_hcount <= '0;
            p1_vcount <= '0;
            p1_hsync  <= 1'b0;
            p1_vsync  <= 1'b0;
            p1_hblnk  <= 1'b0;
            p1_vblnk  <= 1'b0;
            p1_rgb    <= '0;
            p1_hit    <= 1'b0;
            p1_idx    <= '0;
            p1_en     <= 1'b0;
        end else begin
            p1_hcount <= hcount_in;
            p1_vcount <= vcount_in;
            p1_hsync  <= hsync_in;
            p1_vsync  <= vsync_in;
            p1_hblnk  <= hblnk_in;
            p1_vblnk  <= vblnk_in;
            p1_rgb    <= rgb_in;
            p1_hit    <= pix_hit;
            p1_idx    <= pix_idx;
            p1_en     <= menu_en;
        end
    end

`ifdef MENU_CURSOR_EN
    int   cur_dx;
    int   cur_dy;
    logic cursor_hit;

    // Crosshair: a 3-wide vertical bar and a 3-tall horizontal bar, each +/-8 px.
    always_comb begin
        cur_dx     = int'(p1_hcount) - int'(lat_x);
        cur_dy     = int'(p1_vcount) - int'(lat_y);
        cursor_hit = ((cur_dx >= -1) && (cur_dx <= 1) && (cur_dy >= -8) && (cur_dy <= 8)) ||
                     ((cur_dy >= -1) && (cur_dy <= 1) && (cur_dx >= -8) && (cur_dx <= 8));
    end
`endif

    always_comb begin
        pix_rgb = p1_rgb;
        if (p1_en && p1_hit) begin
            if ((state == ST_PRESSED) && (p1_idx == press_idx)) begin
                pix_rgb = COL_PRS;
            end else if (hover_vld && (p1_idx == hover_idx)) begin
                pix_rgb = COL_HOV;
            end else begin
                pix_rgb = COL_BTN;
            end
        end
`ifdef MENU_CURSOR_EN
        if (cursor_hit) begin
            pix_rgb = COL_CURSOR;
        end
`endif
        if (p1_hblnk || p1_vblnk) begin
            pix_rgb = COL_BLANK;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= p1_hcount;
            vcount_out <= p1_vcount;
            hsync_out  <= p1_hsync;
            vsync_out  <= p1_vsync;
            hblnk_out  <= p1_hblnk;
            vblnk_out  <= p1_vblnk;
            rgb_out    <= pix_rgb;
        end
    end

    // Position is only sampled at the start of vsync so a whole frame sees one cursor.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vsync_prev <= 1'b0;
            lat_x      <= '0;
            lat_y      <= '0;
            hover_vld  <= 1'b0;
            hover_idx  <= '0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_in && !vsync_prev) begin
                lat_x <= xpos;
                lat_y <= ypos;
            end
            if (menu_en && mouse_hit) begin
                hover_vld <= 1'b1;
                hover_idx <= mouse_idx;
            end else begin
                hover_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            ml_sync <= 2'b00;
            ml_prev <= 1'b0;
        end else begin
            ml_sync <= {ml_sync[0], mouse_left};
            ml_prev <= ml_sync[1];
        end
    end

    assign press_edge   = ml_sync[1] && !ml_prev;
    assign release_edge = !ml_sync[1] && ml_prev;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            press_idx <= '0;
            sel_idx   <= '0;
        end else begin
            state     <= state_nxt;
            press_idx <= press_idx_nxt;
            sel_idx   <= sel_idx_nxt;
        end
    end

    // Hover may wander off and back while held; only the hover at release matters.
    always_comb begin
        state_nxt     = state;
        press_idx_nxt = press_idx;
        sel_idx_nxt   = sel_idx;
        if (!menu_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press_edge && hover_vld) begin
                        state_nxt     = ST_PRESSED;
                        press_idx_nxt = hover_idx;
                    end
                end
                ST_PRESSED: begin
                    if (release_edge) begin
                        if (hover_vld && (hover_idx == press_idx)) begin
                            state_nxt   = ST_SELECT;
                            sel_idx_nxt = press_idx;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_SELECT: state_nxt = ST_DONE;
                ST_DONE:   state_nxt = ST_DONE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    assign sel_pulse = (state == ST_SELECT);

endmodule

// File: tb/tb_menu_sel_ctl.sv
// tb/tb_menu_sel_ctl.sv - randomized self-checking bench for menu_sel_ctl
module tb_menu_sel_ctl;

    localparam int BX = 272, BW = 256, BY0 = 160, BH = 64, BG = 32, NI = 3;
    localparam int C_BTN = 'h448, C_HOV = 'h88F, C_PRS = 'hFF0;
    localparam int M_IDLE = 0, M_PRESSED = 1, M_SELECT = 2, M_DONE = 3;

    logic        pclk, rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    logic        mouse_left, menu_en;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [2:0]  hover_idx, sel_idx;
    logic        hover_vld, sel_pulse;

    menu_sel_ctl dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .mouse_left(mouse_left), .menu_en(menu_en),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .hover_idx(hover_idx), .hover_vld(hover_vld),
        .sel_idx(sel_idx), .sel_pulse(sel_pulse)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    typedef struct {
        int h; int v; bit hs; bit vs; bit hb; bit vb; int rgb; bit en;
    } pix_t;

    // Reference model: previous pixel sample, mouse-button history, selection state.
    pix_t ph;
    bit   mh [3];
    int   m_state, m_press, m_sel, m_hi, m_lx, m_ly;
    bit   m_hv, m_vsp;
    int   e_hc, e_vc, e_rgb;
    bit   e_hs, e_vs, e_hb, e_vb;

    int   vectors, miscompares, pulses;
    bit   rand_pix;

    function automatic int iabs(int a);
        return (a < 0) ? -a : a;
    endfunction

    // Item containing (x, y), or -1.
    function automatic int item_at(int x, int y);
        int k, off;
        if (x < BX || x >= BX + BW || y < BY0) return -1;
        k   = (y - BY0) / (BH + BG);
        off = (y - BY0) % (BH + BG);
        if (k >= NI || off >= BH) return -1;
        return k;
    endfunction

    task automatic model_reset();
        ph = '{default: 0};
        foreach (mh[i]) mh[i] = 1'b0;
        m_state = M_IDLE; m_press = 0; m_sel = 0; m_hi = 0; m_lx = 0; m_ly = 0;
        m_hv = 1'b0; m_vsp = 1'b0;
        e_hc = 0; e_vc = 0; e_rgb = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
    endtask

    task automatic model_step();
        pix_t p;
        int   k, col;
        bit   prs, rel;
        if (!rst) begin
            model_reset();
            return;
        end
        p = ph;
        ph.h = int'(hcount_in); ph.v = int'(vcount_in);
        ph.hs = hsync_in; ph.vs = vsync_in; ph.hb = hblnk_in; ph.vb = vblnk_in;
        ph.rgb = int'(rgb_in); ph.en = menu_en;

        col = p.rgb;
        k = item_at(p.h, p.v);
        if (p.en && k >= 0) begin
            if (m_state == M_PRESSED && k == m_press) col = C_PRS;
            else if (m_hv && k == m_hi)              col = C_HOV;
            else                                     col = C_BTN;
        end
`ifdef MENU_CURSOR_EN
        if ((iabs(p.h - m_lx) <= 1 && iabs(p.v - m_ly) <= 8) ||
            (iabs(p.v - m_ly) <= 1 && iabs(p.h - m_lx) <= 8)) col = 'hFFF;
`endif
        if (p.hb || p.vb) col = 0;
        e_hc = p.h; e_vc = p.v; e_hs = p.hs; e_vs = p.vs; e_hb = p.hb; e_vb = p.vb; e_rgb = col;

        // button seen through two sync stages: edges come from samples two and three back
        prs = mh[1] && !mh[2];
        rel = !mh[1] && mh[2];
        mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = mouse_left;

        if (!menu_en) m_state = M_IDLE;
        else begin
            case (m_state)
                M_IDLE:    if (prs && m_hv) begin m_state = M_PRESSED; m_press = m_hi; end
                M_PRESSED: if (rel) begin
                               if (m_hv && m_hi == m_press) begin m_state = M_SELECT; m_sel = m_press; end
                               else m_state = M_IDLE;
                           end
                M_SELECT:  m_state = M_DONE;
                default:   m_state = M_DONE;
            endcase
        end

        k = item_at(m_lx, m_ly);
        if (menu_en && k >= 0) begin m_hv = 1'b1; m_hi = k; end
        else m_hv = 1'b0;

        if (vsync_in && !m_vsp) begin m_lx = int'(xpos); m_ly = int'(ypos); end
        m_vsp = vsync_in;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input int exp);
        vectors++;
        chk(name, act, exp);
    endtask

    task automatic randomize_pix();
        if ($urandom_range(0, 3) != 0) begin
            hcount_in = 11'($urandom_range(250, 560));
            vcount_in = 11'($urandom_range(140, 440));
        end else begin
            hcount_in = 11'($urandom);
            vcount_in = 11'($urandom);
        end
        rgb_in   = 12'($urandom);
        hsync_in = 1'($urandom_range(0, 1));
        hblnk_in = ($urandom_range(0, 7) == 0);
        vblnk_in = ($urandom_range(0, 15) == 0);
    endtask

    task automatic cyc();
        @(posedge pclk);
        #1;
        model_step();
        vectors++;
        chk("hcount_out", 32'(hcount_out), e_hc);
        chk("vcount_out", 32'(vcount_out), e_vc);
        chk("hsync_out", 32'(hsync_out), int'(e_hs));
        chk("vsync_out", 32'(vsync_out), int'(e_vs));
        chk("hblnk_out", 32'(hblnk_out), int'(e_hb));
        chk("vblnk_out", 32'(vblnk_out), int'(e_vb));
        chk("rgb_out", 32'(rgb_out), e_rgb);
        chk("hover_vld", 32'(hover_vld), int'(m_hv));
        chk("hover_idx", 32'(hover_idx), m_hi);
        chk("sel_idx", 32'(sel_idx), m_sel);
        chk("sel_pulse", 32'(sel_pulse), (m_state == M_SELECT) ? 1 : 0);
        if (sel_pulse === 1'b1) pulses++;
        if (rand_pix) randomize_pix();
    endtask

    task automatic set_mouse(input int x, input int y);
        xpos = 12'(x); ypos = 12'(y);
        vsync_in = 1'b0; cyc();
        vsync_in = 1'b1; cyc();
        cyc();
    endtask

    task automatic pix_lit(input string name, input int x, input int y, input int bg, input int exp);
        rand_pix = 1'b0;
        hcount_in = 11'(x); vcount_in = 11'(y); rgb_in = 12'(bg);
        hblnk_in = 1'b0; vblnk_in = 1'b0;
        cyc(); cyc();
        lit(name, 32'(rgb_out), exp);
        rand_pix = 1'b1;
    endtask

    task automatic click(input int hold, input int gap);
        mouse_left = 1'b1; repeat (hold) cyc();
        mouse_left = 1'b0; repeat (gap) cyc();
    endtask

    initial begin
        vectors = 0; miscompares = 0; pulses = 0; rand_pix = 1'b1;
        rst = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
        hblnk_in = 0; vblnk_in = 0; rgb_in = '0; xpos = '0; ypos = '0;
        mouse_left = 0; menu_en = 0;
        model_reset();
        #3 rst = 1'b0;

        // reset state
        repeat (3) cyc();
        lit("reset_rgb", 32'(rgb_out), 0);
        lit("reset_hover_vld", 32'(hover_vld), 0);
        lit("reset_sel_pulse", 32'(sel_pulse), 0);
        lit("reset_hcount", 32'(hcount_out), 0);

        // release, menu off: pure 2-cycle pass-through
        rst = 1'b1;
        repeat (20) cyc();
        pix_lit("bypass_menu_off", 300, 180, 'h5A5, 'h5A5);

        // hover item 0
        menu_en = 1'b1;
        set_mouse(300, 180);
        lit("hover_idx_item0", 32'(hover_idx), 0);
        lit("hover_vld_item0", 32'(hover_vld), 1);
`ifdef MENU_CURSOR_EN
        pix_lit("pix_300_180", 300, 180, 'h123, 'hFFF);
`else
        pix_lit("pix_300_180", 300, 180, 'h123, 'h88F);
`endif
        pix_lit("pix_271_180", 271, 180, 'h5A5, 'h5A5);

        // click on item 1: one pulse, then later clicks ignored
        set_mouse(400, 260);
        pulses = 0;
        click(5, 6);
        lit("sel_pulse_count", pulses, 1);
        lit("sel_idx_item1", 32'(sel_idx), 1);
        click(5, 6);
        lit("done_ignores_click", pulses, 1);
        menu_en = 1'b0; repeat (3) cyc();
        lit("sel_idx_retained", 32'(sel_idx), 1);
        menu_en = 1'b1; cyc();

        // press item 0, drag to item 2, release: no selection
        set_mouse(300, 180);
        pulses = 0;
        mouse_left = 1'b1; repeat (5) cyc();
        pix_lit("pressed_colour", 300, 200, 'h321, 'hFF0);
        set_mouse(400, 360);
        lit("hover_item2", 32'(hover_idx), 2);
        mouse_left = 1'b0; repeat (6) cyc();
        lit("drag_no_pulse", pulses, 0);

        // bounds
        set_mouse(528, 160);
        lit("x_bound_excl", 32'(hover_vld), 0);
        set_mouse(527, 223);
        lit("corner_hit_vld", 32'(hover_vld), 1);
        lit("corner_hit_idx", 32'(hover_idx), 0);
        set_mouse(527, 224);
        lit("gap_no_hit", 32'(hover_vld), 0);

        // reset while pressed
        set_mouse(300, 180);
        pulses = 0;
        mouse_left = 1'b1; repeat (5) cyc();
        rst = 1'b0; cyc(); cyc();
        rst = 1'b1; mouse_left = 1'b0; repeat (6) cyc();
        lit("reset_mid_press", pulses, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) vsync_in = ~vsync_in;
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    xpos = 12'($urandom_range(250, 560));
                    ypos = 12'($urandom_range(140, 440));
                end else begin
                    xpos = 12'($urandom);
                    ypos = 12'($urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) mouse_left = ~mouse_left;
            if ($urandom_range(0, 299) == 0) menu_en = ~menu_en;
            rst = ($urandom_range(0, 799) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
